cpu_rst_seq: RTL and testbench

CPU_RST_SEQ -- requirements
Module: cpu_rst_seq

---
 rtl/cpu_rst_seq_pkg.sv | 24 ++
 rtl/cpu_rst_seq_if.sv | 23 ++
 rtl/cpu_rst_seq_sync_2ff.sv | 25 ++
 rtl/cpu_rst_seq.sv | 138 +++++++++++++
 tb/tb_cpu_rst_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_rst_seq_pkg.sv
// cpu_rst_seq_pkg: shared types and constants for the CPU reset sequencer.
// Holds FSM state encoding, reset cause codes, counter width, saturating inc.
package cpu_rst_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR       = 2'd0,
    CAUSE_LOCK_LOSS = 2'd1,
    CAUSE_SW        = 2'd2,
    CAUSE_LOCKUP    = 2'd3
  } cause_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_rst_seq_if.sv
// cpu_rst_seq_if: CPU-side status inputs and reset/status outputs.
// master = sequencer (lockup/halted/sw req in; rstn/ready/cause/cnt out).
interface cpu_rst_seq_if;

  logic       lockup_i;
  logic       halted_i;
  logic       sw_rst_req_i;
  logic       cpu_rstn_o;
  logic       ready_o;
  logic [1:0] rst_cause_o;
  logic [7:0] rst_cnt_o;

  modport master (
    input  lockup_i, halted_i, sw_rst_req_i,
    output cpu_rstn_o, ready_o, rst_cause_o, rst_cnt_o
  );

  modport slave (
    output lockup_i, halted_i, sw_rst_req_i,
    input  cpu_rstn_o, ready_o, rst_cause_o, rst_cnt_o
  );

endinterface

// File: rtl/cpu_rst_seq_sync_2ff.sv
// sync_2ff: two-flop synchroniser with synchronous active-high reset to 0.
// Ports: clk_i, rst_i, d_i (async input), q_o (synchronised output).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/cpu_rst_seq.sv
// cpu_rst_seq: CPU reset sequencer (PLL lock qualify, hold, run, recovery).
// Ports: HCLK_i, hwRst_i, pll_lock_i, bus (cpu_rst_seq_if.master).
// Optional lockup recovery: define CPU_RST_SEQ_LOCKUP_RECOVERY_EN.
module cpu_rst_seq
  import cpu_rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYC    = 1024,
  parameter int RST_HOLD_CYC       = 64,
  parameter int LOCKUP_TIMEOUT_CYC = 4096
) (
  input  logic          HCLK_i,
  input  logic          hwRst_i,
  input  logic          pll_lock_i,
  cpu_rst_seq_if.master bus
);

  localparam logic [CNT_W-1:0] LOCK_RLD = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_RLD = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LK_RLD   = CNT_W'(LOCKUP_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rstn_q, rstn_d;
  cause_e           cause_q, cause_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic             lock_s;
  logic             lk_fire;
  logic             ev_v;
  cause_e           ev_c;

  sync_2ff u_sync (
    .clk_i (HCLK_i),
    .rst_i (hwRst_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

`ifdef CPU_RST_SEQ_LOCKUP_RECOVERY_EN
  logic [CNT_W-1:0] lk_q, lk_d;

  // Only a live (not halted) lockup in RUN counts down; anything else reloads.
  always_comb begin
    lk_d    = LK_RLD;
    lk_fire = 1'b0;
    if (state_q == RUN && bus.lockup_i && !bus.halted_i) begin
      if (lk_q == '0) lk_fire = 1'b1;
      else            lk_d    = lk_q - ONE;
    end
  end

  always_ff @(posedge HCLK_i) begin
    if (hwRst_i) lk_q <= LK_RLD;
    else         lk_q <= lk_d;
  end
`else
  logic unused_lk;
  assign unused_lk = ^{bus.lockup_i, bus.halted_i, LK_RLD};
  assign lk_fire   = 1'b0;
`endif

  always_ff @(posedge HCLK_i) begin
    if (hwRst_i) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= LOCK_RLD;
      rstn_q  <= 1'b0;
      cause_q <= CAUSE_POR;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
      cause_q <= cause_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Event priority: lock loss > sw request > lockup timeout.
  always_comb begin
    state_d = state_q;
    ev_v    = 1'b0;
    ev_c    = CAUSE_POR;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s && cnt_q == '0) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          ev_v    = 1'b1;
          ev_c    = CAUSE_LOCK_LOSS;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          ev_v    = 1'b1;
          ev_c    = CAUSE_LOCK_LOSS;
        end else if (bus.sw_rst_req_i) begin
          state_d = HOLD;
          ev_v    = 1'b1;
          ev_c    = CAUSE_SW;
        end else if (lk_fire) begin
          state_d = HOLD;
          ev_v    = 1'b1;
          ev_c    = CAUSE_LOCKUP;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // The shared counter counts lock stability in WAIT_LOCK and hold time in
  // HOLD; a stay in either state implies cnt_q is nonzero.
  always_comb begin
    cnt_d   = cnt_q;
    cause_d = cause_q;
    rcnt_d  = rcnt_q;
    rstn_d  = (state_d == RUN);
    unique case (state_d)
      WAIT_LOCK: cnt_d = lock_s ? cnt_q - ONE : LOCK_RLD;
      HOLD:      cnt_d = (state_q == HOLD) ? cnt_q - ONE : HOLD_RLD;
      default:   cnt_d = cnt_q;
    endcase
    if (ev_v) begin
      cause_d = ev_c;
      rcnt_d  = sat_inc(rcnt_q);
    end
  end

  assign bus.cpu_rstn_o  = rstn_q;
  assign bus.ready_o     = (state_q == RUN);
  assign bus.rst_cause_o = cause_q;
  assign bus.rst_cnt_o   = rcnt_q;

endmodule

// File: tb/tb_cpu_rst_seq.sv
// tb_cpu_rst_seq: randomized + directed bench for cpu_rst_seq.
// Reference model counts consecutive cycles/events per the sequencing rules.
module tb_cpu_rst_seq;

  localparam int L = 16;
  localparam int H = 8;
  localparam int T = 32;

  logic clk = 1'b0;
  logic rst_r, lock_r, sw_r, lk_r, hl_r;
  int   checks   = 0;
  int   failures = 0;

  cpu_rst_seq_if bus ();

  assign bus.lockup_i     = lk_r;
  assign bus.halted_i     = hl_r;
  assign bus.sw_rst_req_i = sw_r;

  cpu_rst_seq #(
    .LOCK_STABLE_CYC    (L),
    .RST_HOLD_CYC       (H),
    .LOCKUP_TIMEOUT_CYC (T)
  ) dut (
    .HCLK_i     (clk),
    .hwRst_i    (rst_r),
    .pll_lock_i (lock_r),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // model: mode 0 waiting for lock, 1 holding, 2 running
  int m_mode, m_run, m_hold, m_lk, m_cause, m_cnt;
  bit s1, s2;

  function automatic logic [11:0] got();
    return {bus.cpu_rstn_o, bus.ready_o, bus.rst_cause_o, bus.rst_cnt_o};
  endfunction

  function automatic logic [11:0] expv();
    logic r;
    r = (m_mode == 2);
    return {r, r, 2'(m_cause), 8'(m_cnt)};
  endfunction

  task automatic reset_event(input int c);
    m_cause = c;
    m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  task automatic tick();
    bit sl;
    bit fire;
    @(posedge clk);
    if (rst_r) begin
      m_mode = 0; m_run = 0; m_hold = 0; m_lk = 0;
      m_cause = 0; m_cnt = 0; s1 = 0; s2 = 0;
    end else begin
      sl = s2; s2 = s1; s1 = lock_r;
      fire = 0;
`ifdef CPU_RST_SEQ_LOCKUP_RECOVERY_EN
      if (m_mode == 2 && lk_r && !hl_r) m_lk++;
      else m_lk = 0;
      if (m_lk == T) begin
        fire = 1;
        m_lk = 0;
      end
`endif
      case (m_mode)
        0: begin
          m_run = sl ? m_run + 1 : 0;
          if (m_run == L) begin
            m_mode = 1; m_hold = 0;
          end
        end
        1: begin
          if (!sl) begin
            m_mode = 0; m_run = 0; reset_event(1);
          end else begin
            m_hold++;
            if (m_hold == H) m_mode = 2;
          end
        end
        default: begin
          if (!sl) begin
            m_mode = 0; m_run = 0; reset_event(1);
          end else if (sw_r) begin
            m_mode = 1; m_hold = 0; reset_event(2);
          end else if (fire) begin
            m_mode = 1; m_hold = 0; reset_event(3);
          end
        end
      endcase
    end
    #1;
  endtask

  task automatic bring_up();
    rst_r = 1; lock_r = 0; sw_r = 0; lk_r = 0; hl_r = 0;
    tick();
    rst_r = 0; lock_r = 1;
    repeat (30) tick();
  endtask

  task automatic test_reset();
    rst_r = 1; lock_r = 0; sw_r = 0; lk_r = 0; hl_r = 0;
    tick();
    checks++;
    if (got() !== 12'h000) begin
      failures++;
      $display("FAIL reset: got %h want 000", got());
    end
  endtask

  task automatic test_power_up();
    int rise = -1;
    rst_r = 1; lock_r = 0;
    tick();
    rst_r = 0; lock_r = 1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL pwrup e%0d: got %h want %h", e, got(), expv());
      end
      if (rise < 0 && bus.cpu_rstn_o === 1'b1) rise = e;
    end
    checks++;
    if (rise !== 2 + L + H) begin
      failures++;
      $display("FAIL pwrup_edge: got %0d want %0d", rise, 2 + L + H);
    end
  endtask

  task automatic test_glitch();
    int g0, gl, ret, rise;
    g0 = $urandom_range(3, 14);
    gl = $urandom_range(1, 4);
    ret = g0 + gl;
    rise = -1;
    rst_r = 1; lock_r = 0;
    tick();
    rst_r = 0; lock_r = 1;
    for (int e = 1; e <= ret + 40; e++) begin
      tick();
      if (e == g0) lock_r = 0;
      if (e == ret) lock_r = 1;
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL glitch e%0d: got %h want %h", e, got(), expv());
      end
      if (rise < 0 && bus.cpu_rstn_o === 1'b1) rise = e;
    end
    checks++;
    if (rise !== ret + 2 + L + H) begin
      failures++;
      $display("FAIL glitch_edge: got %0d want %0d", rise, ret + 2 + L + H);
    end
  endtask

  task automatic test_lock_loss();
    int rise = -1;
    bring_up();
    lock_r = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL loss e%0d: got %h want %h", e, got(), expv());
      end
      if (e == 2 && bus.cpu_rstn_o !== 1'b1) begin
        failures++;
        $display("FAIL loss_early: got %b want 1", bus.cpu_rstn_o);
      end
    end
    checks++;
    if (got() !== {1'b0, 1'b0, 2'd1, 8'd1}) begin
      failures++;
      $display("FAIL loss_cause: got %h want 101", got());
    end
    lock_r = 1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (rise < 0 && bus.cpu_rstn_o === 1'b1) rise = e;
    end
    checks++;
    if (rise !== 2 + L + H) begin
      failures++;
      $display("FAIL loss_rerun: got %0d want %0d", rise, 2 + L + H);
    end
  endtask

  task automatic test_sw();
    int low = 1;
    bring_up();
    sw_r = 1;
    tick();
    sw_r = 0;
    checks++;
    if (got() !== {1'b0, 1'b0, 2'd2, 8'd1}) begin
      failures++;
      $display("FAIL sw_cause: got %h want 201", got());
    end
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL sw e%0d: got %h want %h", e, got(), expv());
      end
      if (bus.cpu_rstn_o === 1'b0) low++;
    end
    checks++;
    if (low !== H) begin
      failures++;
      $display("FAIL sw_hold: got %0d want %0d", low, H);
    end
  endtask

  task automatic test_lockup();
    int fall = -1;
    int want;
    bring_up();
    lk_r = 1; hl_r = 1;
    repeat (40) tick();
    checks++;
    if (bus.cpu_rstn_o !== 1'b1) begin
      failures++;
      $display("FAIL lockup_halted: got %b want 1", bus.cpu_rstn_o);
    end
    hl_r = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL lockup e%0d: got %h want %h", e, got(), expv());
      end
      if (fall < 0 && bus.cpu_rstn_o === 1'b0) begin
        fall = e;
        checks++;
`ifdef CPU_RST_SEQ_LOCKUP_RECOVERY_EN
        if (bus.rst_cause_o !== 2'd3) begin
`else
        if (bus.rst_cause_o === 2'd3) begin
`endif
          failures++;
          $display("FAIL lockup_cause: got %0d", bus.rst_cause_o);
        end
      end
    end
`ifdef CPU_RST_SEQ_LOCKUP_RECOVERY_EN
    want = T;
`else
    want = -1;
`endif
    checks++;
    if (fall !== want) begin
      failures++;
      $display("FAIL lockup_edge: got %0d want %0d", fall, want);
    end
    lk_r = 0;
  endtask

  task automatic test_collision();
    bring_up();
    lock_r = 0;
    tick();
    tick();
    sw_r = 1;
    tick();
    sw_r = 0;
    checks++;
    if (got() !== {1'b0, 1'b0, 2'd1, 8'd1}) begin
      failures++;
      $display("FAIL collide: got %h want 101", got());
    end
    lock_r = 1;
  endtask

  task automatic test_saturation();
    bring_up();
    for (int i = 0; i < 300; i++) begin
      sw_r = 1;
      tick();
      sw_r = 0;
      repeat (H) tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL sat i%0d: got %h want %h", i, got(), expv());
      end
    end
    checks++;
    if (bus.rst_cnt_o !== 8'd255 || bus.rst_cause_o !== 2'd2) begin
      failures++;
      $display("FAIL sat_final: got cnt=%0d cause=%0d want 255/2",
               bus.rst_cnt_o, bus.rst_cause_o);
    end
  endtask

  task automatic test_abort();
    int rise = -1;
    bring_up();
    sw_r = 1;
    tick();
    sw_r = 0;
    repeat (3) tick();
    rst_r = 1;
    tick();
    rst_r = 0;
    checks++;
    if (got() !== 12'h000) begin
      failures++;
      $display("FAIL abort_hold: got %h want 000", got());
    end
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (rise < 0 && bus.cpu_rstn_o === 1'b1) rise = e;
    end
    checks++;
    if (rise !== 2 + L + H) begin
      failures++;
      $display("FAIL abort_rerun: got %0d want %0d", rise, 2 + L + H);
    end
    rst_r = 1;
    tick();
    rst_r = 0;
    checks++;
    if (got() !== 12'h000) begin
      failures++;
      $display("FAIL abort_run: got %h want 000", got());
    end
  endtask

  task automatic test_random();
    rst_r = 1; lock_r = 0; sw_r = 0; lk_r = 0; hl_r = 0;
    tick();
    rst_r = 0;
    for (int i = 0; i < 2000; i++) begin
      rst_r  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) lock_r = ~lock_r;
      if (!lock_r && $urandom_range(0, 3) == 0) lock_r = 1;
      sw_r   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) lk_r = ~lk_r;
      hl_r   = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL rand i%0d: got %h want %h", i, got(), expv());
      end
    end
    rst_r = 0; sw_r = 0; lk_r = 0; hl_r = 0;
  endtask

  initial begin
    rst_r = 1; lock_r = 0; sw_r = 0; lk_r = 0; hl_r = 0;
    m_mode = 0; m_run = 0; m_hold = 0; m_lk = 0;
    m_cause = 0; m_cnt = 0; s1 = 0; s2 = 0;
    test_reset();
    test_power_up();
    test_glitch();
    test_lock_loss();
    test_sw();
    test_lockup();
    test_collision();
    test_saturation();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
